// File: rtl/and8_share_sched.sv
// and8_share_sched
//   Round-robin scheduler sharing one external 8-input AND datapath among
//   NUM_REQ requesters. One request is served at a time: its operand is
//   registered onto and_a_o, held for SETTLE_CYC cycles, then and_b_i is
//   sampled and returned with the requester id. Each sampled result is
//   compared against a local &operand. Mismatches raise rsp_err_o and bump a
//   saturating counter, which allows a netlist to be checked against golden.
// Ports
//   clk, rst     clock and synchronous active-high reset
//   req_valid_i  per-requester valid
//   req_data_i   per-requester operand, lane i = bits [8*i+7:8*i]
//   req_ready_o  one-hot grant (combinational, IDLE only)
//   and_a_o      operand to the shared AND datapath (registered)
//   and_b_i      result from the shared AND datapath
//   rsp_*        response handshake, id, sampled data, mismatch flag
//   err_cnt_o    saturating mismatch count
module and8_share_sched #(
  parameter int NUM_REQ    = 4,
  parameter int SETTLE_CYC = 1,
  parameter int ERRCNT_W   = 16,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0][7:0] req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [7:0]              and_a_o,
  input  logic                    and_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic                    rsp_data_o,
  output logic                    rsp_err_o,
  output logic [ERRCNT_W-1:0]     err_cnt_o
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [7:0]          op_q, op_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx;
  logic                mismatch;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  // Grant is suppressed during reset so nothing is handshaken that reset drops.
  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && !rst && gnt_found) req_ready_o[gnt_idx] = 1'b1;
  end

  // X/Z on and_b counts as a mismatch.
  assign mismatch = (and_b_i !== (&op_q));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          op_d    = req_data_i[gnt_idx];
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_data_d  = and_b_i;
          rsp_err_d   = mismatch;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
          if (mismatch && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      op_q        <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign and_a_o     = op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_and8_share_sched.sv
// Bench for and8_share_sched: directed scenarios with literal expectations,
// then randomized traffic. A transaction-level model predicts every output
// on every cycle; a queue scoreboard checks in-order single answers.
module tb_and8_share_sched;
  localparam int N  = 4;
  localparam int SC = 1;

  logic clk = 1'b0, rst = 1'b1, rr = 1'b1, fault = 1'b0;
  logic [N-1:0] rv = '0;
  logic [N-1:0][7:0] rd = '0;

  logic [N-1:0] rdy, rdy2;
  logic [7:0]   and_a, and_a2;
  logic         and_b, and_b2;
  logic         rsp_valid, rsp_valid2, rsp_data, rsp_data2, rsp_err, rsp_err2;
  logic [1:0]   rsp_id, rsp_id2;
  logic [15:0]  err_cnt;
  logic [1:0]   err_cnt2;

  assign and_b  = fault ? ~(&and_a) : (&and_a);
  assign and_b2 = ~(&and_a2);

  and8_share_sched #(.NUM_REQ(N), .SETTLE_CYC(SC), .ERRCNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid_i(rv), .req_data_i(rd), .req_ready_o(rdy),
    .and_a_o(and_a), .and_b_i(and_b), .rsp_valid_o(rsp_valid), .rsp_ready_i(rr),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .err_cnt_o(err_cnt));

  // Always-faulty datapath on a 2-bit counter build: exercises saturation.
  and8_share_sched #(.NUM_REQ(N), .SETTLE_CYC(SC), .ERRCNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid_i(rv), .req_data_i(rd), .req_ready_o(rdy2),
    .and_a_o(and_a2), .and_b_i(and_b2), .rsp_valid_o(rsp_valid2), .rsp_ready_i(rr),
    .rsp_id_o(rsp_id2), .rsp_data_o(rsp_data2), .rsp_err_o(rsp_err2), .err_cnt_o(err_cnt2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: busy = operand being settled, left = settle cycles remaining,
  // mrv = response outstanding. Idle means neither.
  int mptr = 0, mid = 0, mleft = 0, mrid = 0, merr = 0, merr2 = 0;
  logic [7:0] mop = '0;
  bit mbusy = 0, mrv = 0, mrdata = 0, mrerr = 0;

  int sbq[$], glog[$], rlog[$], elog[$];
  int gcnt = 0;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (!rst && !mbusy && !mrv)
      for (int k = 0; k < N; k++)
        if (r == '0 && rv[(mptr + k) % N]) r[(mptr + k) % N] = 1'b1;
    return r;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] er;
    er = exp_ready();
    chk("req_ready", rdy, er);
    chk("and_a", and_a, mop);
    chk("rsp_valid", rsp_valid, mrv);
    chk("rsp_id", rsp_id, mrid);
    chk("rsp_data", rsp_data, mrdata);
    chk("rsp_err", rsp_err, mrerr);
    chk("err_cnt", err_cnt, merr);
    chk("err_cnt2", err_cnt2, merr2);
    // Scoreboard: responses must match grants in order, once each.
    if (rst) sbq.delete();
    else begin
      for (int i = 0; i < N; i++)
        if (rv[i] && rdy[i]) begin sbq.push_back(i); glog.push_back(i); gcnt++; end
      if (rsp_valid && rr) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_rsp actual_id=%0d expected=none", rsp_id);
        end else chk("sb_order", rsp_id, sbq.pop_front());
        rlog.push_back(int'(rsp_data));
        elog.push_back(int'(rsp_err));
      end
    end
    // Advance model across the coming rising edge.
    if (rst) begin
      mptr = 0; mid = 0; mleft = 0; mrid = 0; merr = 0; merr2 = 0;
      mop = '0; mbusy = 0; mrv = 0; mrdata = 0; mrerr = 0;
    end else if (er != '0) begin
      for (int i = 0; i < N; i++)
        if (er[i]) begin mop = rd[i]; mid = i; mptr = (i + 1) % N; end
      mbusy = 1; mleft = SC;
    end else if (mbusy) begin
      if (mleft == 1) begin
        mbusy = 0; mrv = 1; mrid = mid;
        mrdata = fault ? ~(&mop) : (&mop);
        mrerr = fault;
        if (fault && merr < 65535) merr++;
        if (merr2 < 3) merr2++;
      end else mleft--;
    end else if (mrv && rr) mrv = 0;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int eg[5] = '{0, 1, 2, 3, 0};
  int ed[5] = '{1, 0, 0, 0, 1};
  int base, cyc;
  logic [N-1:0] hs;

  initial begin
    // 1: reset with all requests pending
    rv = '1; rd = {8'h12, 8'h34, 8'h56, 8'h78};
    repeat (3) tick();
    @(negedge clk);
    chk("t1_ready", rdy, 0); chk("t1_and_a", and_a, 0); chk("t1_rsp_valid", rsp_valid, 0);
    chk("t1_rsp_id", rsp_id, 0); chk("t1_err_cnt", err_cnt, 0);
    tick();
    // 2: single request latency
    rst = 1'b0; rv = 4'b0001; rd[0] = 8'hFF; rr = 1'b1;
    @(negedge clk); chk("t2_grant", rdy, 4'b0001);
    tick(); rv = '0;
    @(negedge clk); chk("t2_and_a", and_a, 8'hFF); chk("t2_no_rsp_yet", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 1); chk("t2_rsp_id", rsp_id, 0);
    chk("t2_rsp_data", rsp_data, 1); chk("t2_rsp_err", rsp_err, 0);
    tick();
    // 3: all four pending, round-robin order from ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    glog.delete(); rlog.delete(); elog.delete();
    rd = {8'h00, 8'hFE, 8'h7F, 8'hFF}; rv = '1;
    for (cyc = 0; cyc < 100 && glog.size() < 5; cyc++) tick();
    chk("t3_grant_count", glog.size(), 5);
    rv = '0;
    repeat (4) tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_grant_order", (k < glog.size()) ? glog[k] : -1, eg[k]);
      chk("t3_rsp_data", (k < rlog.size()) ? rlog[k] : -1, ed[k]);
    end
    chk("t3_err_cnt", err_cnt, 0);
    // 4: backpressure on the response, ptr=1 now
    rd[1] = 8'h55; rv = 4'b0010; rr = 1'b0;
    @(negedge clk); chk("t4_grant", rdy, 4'b0010);
    tick(); rv = '1;
    tick();
    @(negedge clk);
    chk("t4_rsp_valid", rsp_valid, 1); chk("t4_rsp_id", rsp_id, 1); chk("t4_rsp_data", rsp_data, 0);
    repeat (5) begin
      tick();
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 1); chk("t4_hold_id", rsp_id, 1); chk("t4_no_grant", rdy, 0);
    end
    tick(); rr = 1'b1;
    @(negedge clk); chk("t4_accept_no_grant", rdy, 0);
    tick();
    @(negedge clk); chk("t4_next_grant", rdy, 4'b0100);
    tick(); rv = '0;
    repeat (4) tick();
    // 5: faulty datapath, mismatch counting and 2-bit saturation
    fault = 1'b1; elog.delete(); rv = '1;
    repeat (12) tick();
    rv = '0;
    repeat (4) tick();
    chk("t5_enough_rsp", elog.size() >= 3, 1);
    foreach (elog[k]) chk("t5_rsp_err", elog[k], 1);
    chk("t5_err_cnt", err_cnt, elog.size());
    chk("t5_err_cnt_sat", err_cnt2, 3);
    fault = 1'b0;
    // 6: reset during DRIVE discards the in-flight request
    rd[2] = 8'hAB; rv = 4'b0100;
    @(negedge clk); chk("t6_grant", rdy, 4'b0100);
    tick(); rst = 1'b1; rv = 4'b0110;
    tick(); rst = 1'b0;
    @(negedge clk); chk("t6_no_rsp", rsp_valid, 0); chk("t6_lowest_grant", rdy, 4'b0010);
    tick(); rv = '0;
    repeat (4) tick();
    // Random traffic against the ideal datapath
    rst = 1'b1; tick(); rst = 1'b0;
    base = gcnt;
    for (cyc = 0; cyc < 60000 && gcnt - base < 3000; cyc++) begin
      @(negedge clk); hs = rv & rdy;
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !rv[i]) begin
          rv[i] = ($urandom_range(2) == 0);
          rd[i] = 8'($urandom);
          if ($urandom_range(3) == 0) rd[i] = 8'hFF;
        end else if ($urandom_range(49) == 0) rv[i] = 1'b0;
      end
      rr = ($urandom_range(9) < 7);
    end
    chk("rand_grants_done", (gcnt - base) >= 3000, 1);
    rv = '0; rr = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("rand_err_cnt", err_cnt, 0);
    chk("rand_sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
